sd_pad_bank: RTL

Parametrised bidirectional pad bank for the SD card DAT bus. It replaces the single-bit pad with WIDTH lanes. It adds:
- 1-bit or full-width bus mode
- input synchronisers
- a direction-change state machine with hi-Z turnaround
- a direction handshake
- start-bit detection on lane 0

It sits between the DAT serialiser/deserialiser logic and the top-level inout pins.

---
 rtl/sd_pad_pkg.sv | 19 +
 rtl/sd_pad_sync.sv | 26 ++
 rtl/sd_pad_bank.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sd_pad_pkg.sv
// Shared state encoding and lane constants for the SD DAT pad bank.
// No datapath of its own; no flow control.
package sd_pad_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_IN       = 3'd1,
    ST_TURN_OUT = 3'd2,
    ST_OUT      = 3'd3,
    ST_TURN_IN  = 3'd4
  } pad_state_e;

  localparam logic IDLE_LEVEL = 1'b1;

  localparam int MAX_LANES = 8;
  // Narrow (1-bit) bus mode keeps only lane 0 active.
  localparam logic [MAX_LANES-1:0] LANE0_MASK = 8'h01;

endpackage

// File: rtl/sd_pad_sync.sv
// One pad lane's input synchroniser, STAGES flops, reset to the SD idle level.
// Latency STAGES cycles; free-running, no flow control.
module sd_pad_sync
  import sd_pad_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock) begin
    if (!reset) begin
      chain <= {STAGES{IDLE_LEVEL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sd_pad_bank.sv
// WIDTH-lane bidirectional SD DAT pad bank with hi-Z turnaround and lane-0 start-bit detect.
// Pad-to-data_out SYNC_STAGES cycles, data_in-to-pad 1 cycle; no backpressure, dir_ack/busy report direction.
module sd_pad_bank
  import sd_pad_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TURNAROUND  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir_req,
  input  logic             wide_mode,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  inout  wire  [WIDTH-1:0] io_port,
  output logic             dir_ack,
  output logic             busy,
  output logic             start_detect
);

  localparam int CNT_W = $clog2(TURNAROUND + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TURNAROUND - 1);

  pad_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] out_reg;
  logic             wide_q;
  logic [WIDTH-1:0] lane_en;
  logic [WIDTH-1:0] sync_q;
  logic             lane0_prev;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_DISABLED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A direction request is only looked at in the settled IN/OUT states.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!enable) begin
      state_nxt = ST_DISABLED;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ST_DISABLED: state_nxt = ST_IN;
        ST_IN: begin
          if (dir_req) begin
            state_nxt = ST_TURN_OUT;
            cnt_nxt   = CNT_LOAD;
          end
        end
        ST_TURN_OUT: begin
          if (cnt == '0) state_nxt = ST_OUT;
          else           cnt_nxt   = cnt - 1'b1;
        end
        ST_OUT: begin
          if (!dir_req) begin
            state_nxt = ST_TURN_IN;
            cnt_nxt   = CNT_LOAD;
          end
        end
        ST_TURN_IN: begin
          if (cnt == '0) state_nxt = ST_IN;
          else           cnt_nxt   = cnt - 1'b1;
        end
        default: state_nxt = ST_DISABLED;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_reg <= {WIDTH{IDLE_LEVEL}};
      wide_q  <= 1'b0;
    end else begin
      out_reg <= enable ? data_in : {WIDTH{IDLE_LEVEL}};
      wide_q  <= wide_mode;
    end
  end

  assign lane_en = wide_q ? {WIDTH{1'b1}} : LANE0_MASK[WIDTH-1:0];

  // Pad enables come straight from the state register so reset or disable
  // releases every pad on the very next cycle.
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    assign io_port[g] = (state == ST_OUT && lane_en[g]) ? out_reg[g] : 1'bz;

    sd_pad_sync #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clock(clock),
      .reset(reset),
      .d    (io_port[g]),
      .q    (sync_q[g])
    );
  end

  assign data_out = (state == ST_IN) ? (sync_q | ~lane_en) : {WIDTH{IDLE_LEVEL}};
  assign dir_ack  = (state == ST_OUT);
  assign busy     = (state == ST_TURN_OUT) || (state == ST_TURN_IN);

  // Previous lane-0 level is held at idle outside IN so a line already low
  // on entry still yields one start pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lane0_prev   <= IDLE_LEVEL;
      start_detect <= 1'b0;
    end else begin
      start_detect <= (state == ST_IN) && !sync_q[0] && lane0_prev;
      lane0_prev   <= (state == ST_IN) ? sync_q[0] : IDLE_LEVEL;
    end
  end

endmodule
